// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the DOF -> EX -> WB pipeline control logic.
//   REG_AW       register address width (address 0 is the hardwired zero reg)
//   PERF_W       width of the optional stall counter (HAZ_PERF_CNT_EN)
//   REG_ZERO     the zero register address
//   stage_slot_t one pipeline stage's producer record {vld, rw, ld, da}
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int REG_AW = 5;
  localparam int PERF_W = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              vld;
    logic              rw;
    logic              ld;
    logic [REG_AW-1:0] da;
  } stage_slot_t;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl_if
// Bundle between the decode stage / register_file and the hazard scheduler.
//   Decode -> scheduler : hold, flush, dof_vld, dof_aa, dof_ba, dof_ma,
//                         dof_mb, dof_rw, dof_da, dof_ld
//   Scheduler -> decode : ha, hb, stall, ex_bubble
//                         stall_cnt (only when HAZ_PERF_CNT_EN is defined)
// Modports: master = decode side, slave = hazard_fwd_ctrl.
// Optional feature macro: HAZ_PERF_CNT_EN.
// ---------------------------------------------------------------------------
interface hazard_fwd_ctrl_if;

  logic                        hold;
  logic                        flush;
  logic                        dof_vld;
  logic [pipe_pkg::REG_AW-1:0] dof_aa;
  logic [pipe_pkg::REG_AW-1:0] dof_ba;
  logic                        dof_ma;
  logic                        dof_mb;
  logic                        dof_rw;
  logic [pipe_pkg::REG_AW-1:0] dof_da;
  logic                        dof_ld;

  logic                        ha;
  logic                        hb;
  logic                        stall;
  logic                        ex_bubble;
`ifdef HAZ_PERF_CNT_EN
  logic [pipe_pkg::PERF_W-1:0] stall_cnt;
`endif

  modport master (
    output hold, flush, dof_vld, dof_aa, dof_ba, dof_ma, dof_mb,
           dof_rw, dof_da, dof_ld,
`ifdef HAZ_PERF_CNT_EN
    input  stall_cnt,
`endif
    input  ha, hb, stall, ex_bubble
  );

  modport slave (
    input  hold, flush, dof_vld, dof_aa, dof_ba, dof_ma, dof_mb,
           dof_rw, dof_da, dof_ld,
`ifdef HAZ_PERF_CNT_EN
    output stall_cnt,
`endif
    output ha, hb, stall, ex_bubble
  );

endinterface

// File: rtl/hazard_cmp.sv
// ---------------------------------------------------------------------------
// hazard_cmp
// Compares one producer slot against one DOF operand address.
//   i_slot     producer record (EX or WB stage)
//   i_addr     operand register address
//   i_src_sel  operand is taken from a non-register source (PC_1 / CONST_B)
//   o_match    producer writes the register this operand reads
//   o_match_ld the matching producer is a load
// ---------------------------------------------------------------------------
module hazard_cmp
  import pipe_pkg::*;
(
  input  stage_slot_t       i_slot,
  input  logic [REG_AW-1:0] i_addr,
  input  logic              i_src_sel,
  output logic              o_match,
  output logic              o_match_ld
);

  // Writes to the zero register are discarded by register_file, so they
  // can never be a real dependency.
  assign o_match = i_slot.vld & i_slot.rw & (i_slot.da != REG_ZERO) &
                   (i_slot.da == i_addr) & ~i_src_sel;

  assign o_match_ld = o_match & i_slot.ld;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
// Hazard / forwarding scheduler for the 3-stage DOF -> EX -> WB pipeline.
// Tracks EX and WB destinations, drives register_file HA/HB to select the
// FWD bus (EX result) and stalls DOF for hazards forwarding cannot cover
// (a load in EX, or any producer still in WB).
//   clk    pipeline clock
//   rst_n  asynchronous active-low reset
//   bus    hazard_fwd_ctrl_if.slave (decode inputs, ha/hb/stall/ex_bubble)
// Optional feature macro: HAZ_PERF_CNT_EN adds the bus.stall_cnt counter.
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  hazard_fwd_ctrl_if.slave bus
);

  stage_slot_t r_exSlot;
  stage_slot_t r_wbSlot;
  stage_slot_t w_exNext;
  stage_slot_t w_wbNext;

  logic w_dofLive;
  logic w_exAHit, w_exALdHit, w_exBHit, w_exBLdHit;
  logic w_wbAHit, w_wbALdHit, w_wbBHit, w_wbBLdHit;
  logic w_exA, w_exALd, w_exB, w_exBLd, w_wbA, w_wbB;
  logic w_stall;
  logic w_bubble;
  logic w_unusedWbLd;

  // A discarded or empty DOF slot has no operands to protect.
  assign w_dofLive = bus.dof_vld & ~bus.flush;

  hazard_cmp u_cmpExA (
    .i_slot(r_exSlot), .i_addr(bus.dof_aa), .i_src_sel(bus.dof_ma),
    .o_match(w_exAHit), .o_match_ld(w_exALdHit)
  );

  hazard_cmp u_cmpExB (
    .i_slot(r_exSlot), .i_addr(bus.dof_ba), .i_src_sel(bus.dof_mb),
    .o_match(w_exBHit), .o_match_ld(w_exBLdHit)
  );

  hazard_cmp u_cmpWbA (
    .i_slot(r_wbSlot), .i_addr(bus.dof_aa), .i_src_sel(bus.dof_ma),
    .o_match(w_wbAHit), .o_match_ld(w_wbALdHit)
  );

  hazard_cmp u_cmpWbB (
    .i_slot(r_wbSlot), .i_addr(bus.dof_ba), .i_src_sel(bus.dof_mb),
    .o_match(w_wbBHit), .o_match_ld(w_wbBLdHit)
  );

  // The WB slot never holds a load flag, so its load matches carry nothing.
  assign w_unusedWbLd = w_wbALdHit | w_wbBLdHit;

  assign w_exA   = w_exAHit & w_dofLive;
  assign w_exALd = w_exALdHit & w_dofLive;
  assign w_exB   = w_exBHit & w_dofLive;
  assign w_exBLd = w_exBLdHit & w_dofLive;
  assign w_wbA   = w_wbAHit & w_dofLive;
  assign w_wbB   = w_wbBHit & w_dofLive;

  // Load data only exists in WB, so a load in EX cannot be forwarded. A WB
  // producer is stalled on because register_file only returns the new value
  // the cycle after the write, unless a younger EX producer of the same
  // register already supplies the operand.
  assign w_stall = w_exALd | w_exBLd | (w_wbA & ~w_exA) | (w_wbB & ~w_exB);

  assign bus.ha        = w_exA & ~w_exALd & ~w_stall;
  assign bus.hb        = w_exB & ~w_exBLd & ~w_stall;
  assign bus.stall     = w_stall;
  assign w_bubble      = w_stall | bus.flush | ~bus.dof_vld;
  assign bus.ex_bubble = w_bubble;

  // Next contents of the two tracked stages.
  always_comb begin
    w_exNext = '0;
    if (!w_bubble) begin
      w_exNext = {1'b1, bus.dof_rw, bus.dof_ld, bus.dof_da};
    end
    w_wbNext    = r_exSlot;
    w_wbNext.ld = 1'b0;
  end

  // hold freezes the whole pipeline, including a pending flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exSlot <= '0;
      r_wbSlot <= '0;
    end else if (!bus.hold) begin
      r_exSlot <= w_exNext;
      r_wbSlot <= w_wbNext;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] r_stallCnt;

  // Counts cycles in which a stall actually costs an issue slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
    end else if (w_stall && !bus.hold) begin
      r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

  assign bus.stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
// Directed bench for hazard_fwd_ctrl: a table of per-cycle decode inputs
// with hand-computed ha/hb/stall/ex_bubble, followed by hand-written
// sequences for flush, hold, the stall counter and reset during a stall.
// Optional feature macro: HAZ_PERF_CNT_EN enables the stall_cnt checks.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

  typedef struct {
    string      name;
    logic       hold;
    logic       flush;
    logic       vld;
    logic [4:0] aa;
    logic [4:0] ba;
    logic       ma;
    logic       mb;
    logic       rw;
    logic [4:0] da;
    logic       ld;
    logic       eHa;
    logic       eHb;
    logic       eStall;
    logic       eBub;
  } vec_t;

  logic clk;
  logic rst_n;
  int   assertCount;
  int   failCount;
  vec_t vecs[16];
  vec_t v;

  hazard_fwd_ctrl_if bus ();

  hazard_fwd_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(string name, logic hold, logic flush, logic vld,
                              logic [4:0] aa, logic [4:0] ba, logic ma,
                              logic mb, logic rw, logic [4:0] da, logic ld,
                              logic eHa, logic eHb, logic eStall, logic eBub);
    vec_t r;
    r.name = name; r.hold = hold; r.flush = flush; r.vld = vld;
    r.aa = aa; r.ba = ba; r.ma = ma; r.mb = mb; r.rw = rw; r.da = da;
    r.ld = ld; r.eHa = eHa; r.eHb = eHb; r.eStall = eStall; r.eBub = eBub;
    return r;
  endfunction

  // Drives one cycle's worth of decode inputs.
  task automatic applyStimulus(input vec_t s);
    bus.hold    = s.hold;
    bus.flush   = s.flush;
    bus.dof_vld = s.vld;
    bus.dof_aa  = s.aa;
    bus.dof_ba  = s.ba;
    bus.dof_ma  = s.ma;
    bus.dof_mb  = s.mb;
    bus.dof_rw  = s.rw;
    bus.dof_da  = s.da;
    bus.dof_ld  = s.ld;
  endtask

  // One comparison: counts it, reports a failure on one line.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input vec_t s);
    checkOutput({s.name, ".ha"},        32'(bus.ha),        32'(s.eHa));
    checkOutput({s.name, ".hb"},        32'(bus.hb),        32'(s.eHb));
    checkOutput({s.name, ".stall"},     32'(bus.stall),     32'(s.eStall));
    checkOutput({s.name, ".ex_bubble"}, 32'(bus.ex_bubble), 32'(s.eBub));
  endtask

  // Apply inputs just after a rising edge, check on the falling edge, then
  // let the next rising edge advance the pipeline.
  task automatic runRow(input vec_t s);
    applyStimulus(s);
    @(negedge clk);
    checkAll(s);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(mk("rst", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    checkAll(mk("reset", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef HAZ_PERF_CNT_EN
    checkOutput("reset.stall_cnt", bus.stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst_n       = 1'b0;

    //                name     hold fl vld aa  ba ma mb rw da ld  ha hb st bub
    vecs[0]  = mk("idle",      0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[1]  = mk("aluW3",     0, 0, 1, 1,  2, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    vecs[2]  = mk("fwdA3",     0, 0, 1, 3,  2, 0, 0, 1, 8, 0, 1, 0, 0, 0);
    vecs[3]  = mk("ldW5",      0, 0, 1, 9, 10, 0, 0, 1, 5, 1, 0, 0, 0, 0);
    vecs[4]  = mk("ldUse1",    0, 0, 1, 11, 5, 0, 0, 1, 12, 0, 0, 0, 1, 1);
    vecs[5]  = mk("ldUse2",    0, 0, 1, 11, 5, 0, 0, 1, 12, 0, 0, 0, 1, 1);
    vecs[6]  = mk("ldIssue",   0, 0, 1, 11, 5, 0, 0, 1, 12, 0, 0, 0, 0, 0);
    vecs[7]  = mk("aluW7",     0, 0, 1, 0,  0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
    vecs[8]  = mk("unrel",     0, 0, 1, 1,  2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk("wbStall",   0, 0, 1, 7,  1, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    vecs[10] = mk("wbIssue",   0, 0, 1, 7,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk("readR0",    0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk("aluW4",     0, 0, 1, 1,  2, 0, 0, 1, 4, 0, 0, 0, 0, 0);
    vecs[13] = mk("maMask",    0, 0, 1, 4,  2, 1, 0, 1, 4, 0, 0, 0, 0, 0);
    vecs[14] = mk("dualFwd",   0, 0, 1, 4,  4, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    vecs[15] = mk("mbMask",    0, 0, 1, 1,  4, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset and table-driven vectors");
    doReset();
    for (int i = 0; i < 16; i++) begin
      runRow(vecs[i]);
    end

    $display("[TB] flush during load-use stall");
    doReset();
    runRow(mk("flLoad",  0, 0, 1, 1,  2, 0, 0, 1, 5, 1, 0, 0, 0, 0));
    runRow(mk("flUse",   0, 1, 1, 11, 5, 0, 0, 1, 6, 0, 0, 0, 0, 1));
    // If the flushed reader had entered EX, reading R6 would forward.
    runRow(mk("flAfter", 0, 0, 1, 6,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("[TB] hold during load-use stall");
    doReset();
    runRow(mk("hdLoad",  0, 0, 1, 1,  2, 0, 0, 1, 5, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      runRow(mk("hdFrozen", 1, 0, 1, 11, 5, 0, 0, 1, 12, 0, 0, 0, 1, 1));
    end
`ifdef HAZ_PERF_CNT_EN
    checkOutput("hdFrozen.stall_cnt", bus.stall_cnt, 32'd0);
`endif
    runRow(mk("hdUse1",  0, 0, 1, 11, 5, 0, 0, 1, 12, 0, 0, 0, 1, 1));
    runRow(mk("hdUse2",  0, 0, 1, 11, 5, 0, 0, 1, 12, 0, 0, 0, 1, 1));
    v = mk("hdIssue", 0, 0, 1, 11, 5, 0, 0, 1, 12, 0, 0, 0, 0, 0);
    applyStimulus(v);
    @(negedge clk);
    checkAll(v);
`ifdef HAZ_PERF_CNT_EN
    checkOutput("hdIssue.stall_cnt", bus.stall_cnt, 32'd2);
`endif
    @(posedge clk);
    #1;

    $display("[TB] reset pulse in mid-stall");
    runRow(mk("rsLoad",  0, 0, 1, 1,  2, 0, 0, 1, 9, 1, 0, 0, 0, 0));
    v = mk("rsUse", 0, 0, 1, 9, 3, 0, 0, 1, 10, 0, 0, 0, 1, 1);
    applyStimulus(v);
    @(negedge clk);
    checkAll(v);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rsAsync.stall", 32'(bus.stall), 32'd0);
    checkOutput("rsAsync.ex_bubble", 32'(bus.ex_bubble), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    checkOutput("rsAsync.stall_cnt", bus.stall_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
